// File: rtl/terminal_state_pkg.sv
// Field positions of the terminal status word, shared with the software
// header generator, plus a small lane-count helper.
package terminal_state_pkg;

  localparam int LEVEL_LSB  = 0;
  localparam int FLAG_LSB   = 8;
  localparam int COUNT_LSB  = 16;
  localparam int IRQ_BIT    = 31;
  localparam int MAX_INPUTS = 8;

  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {7'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/terminal_state_debounce.sv
// One input lane: synchroniser chain, hold counter, accepted level and a
// one-cycle strobe that is high in the cycle after a new level is accepted.
module terminal_state_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic chg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Counter only runs while the synchronised input disagrees with the level;
  // any return to the current level restarts the hold period.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      chg   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      chg  <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s;
        cnt   <= '0;
        chg   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/terminal_state_collector.sv
// Debounces up to eight front-panel inputs and packs levels, sticky change
// flags and a rolling change count into one registered status word.
module terminal_state_collector
  import terminal_state_pkg::*;
#(
  parameter int N_INPUTS        = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  input  logic                clr_pulse,
  input  logic [7:0]          clr_mask,
  output logic [31:0]         state_word,
  output logic                change_irq
);

  localparam logic [7:0] LANE_MASK = 8'((1 << N_INPUTS) - 1);

  logic [MAX_INPUTS-1:0] level;
  logic [MAX_INPUTS-1:0] chg;
  logic [7:0]            clr;
  logic [7:0]            flags_next;
  logic [7:0]            count_next;
  logic [31:0]           word_next;

  for (genvar i = 0; i < MAX_INPUTS; i++) begin : g_lane
    if (i < N_INPUTS) begin : g_used
      terminal_state_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_in[i]),
        .level (level[i]),
        .chg   (chg[i])
      );
    end else begin : g_unused
      assign level[i] = 1'b0;
      assign chg[i]   = 1'b0;
    end
  end

  // The output register is the only copy of flags and count, so every field
  // of a new word is derived from the same edge; a new change beats a clear.
  always_comb begin
    clr        = clr_pulse ? (clr_mask & LANE_MASK) : 8'h00;
    flags_next = (state_word[FLAG_LSB +: 8] & ~clr) | chg;
    count_next = state_word[COUNT_LSB +: 8] + popcount8(chg);
    word_next                    = '0;
    word_next[LEVEL_LSB +: 8]    = level;
    word_next[FLAG_LSB +: 8]     = flags_next;
    word_next[COUNT_LSB +: 8]    = count_next;
    word_next[IRQ_BIT]           = |flags_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_word <= '0;
      change_irq <= 1'b0;
    end else begin
      state_word <= word_next;
      change_irq <= |flags_next;
    end
  end

endmodule
